ctrl_pc_redirect: RTL and testbench

Fetch-side PC sequencer and redirect/squash controller for the 8-bit RISC-RNS pipeline (IF → IFID → EX → MEMWB). It consumes the branch predictor's `branch_taken` decision and the jump target of the instruction in IFID. It redirects the fetch PC and produces the `invalidate_instr` squash flag that the predictor and the IFID/EX stages consume for the one wrong-path instruction. It also handles pipeline stall hold and halt, and keeps a saturating count of taken redirects.

---
 rtl/ctrl_pc_redirect_if.sv | 24 ++
 rtl/ctrl_pc_redirect.sv | 71 +++++++
 tb/tb_ctrl_pc_redirect.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pc_redirect_if.sv
// Fetch-control bundle between the pipeline (hazard unit, predictor, IFID decode)
// and the PC redirect controller.
interface ctrl_pc_redirect_if #(
  parameter int unsigned PC_W = 8
);
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] jump_target;
  logic            halt;
  logic [PC_W-1:0] pc;
  logic            invalidate_instr;
  logic            halted;
  logic [7:0]      taken_count;

  modport master (
    output stall, branch_taken, jump_target, halt,
    input  pc, invalidate_instr, halted, taken_count
  );

  modport slave (
    input  stall, branch_taken, jump_target, halt,
    output pc, invalidate_instr, halted, taken_count
  );
endinterface

// File: rtl/ctrl_pc_redirect.sv
// Fetch PC sequencer with one-bubble taken-branch squash, stall hold, halt and a
// saturating redirect counter. All outputs are registered.
module ctrl_pc_redirect #(
  parameter int unsigned    PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset_n,
  ctrl_pc_redirect_if.slave bus
);

  typedef enum logic [1:0] {StRun, StSquash, StHalt} state_e;

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_invalidate;
  logic            r_halted;
  logic [7:0]      r_taken_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StRun;
      r_pc          <= RESET_PC;
      r_invalidate  <= 1'b0;
      r_halted      <= 1'b0;
      r_taken_count <= 8'h00;
    end else begin
      unique case (r_state)
        StRun: begin
          // A stall also holds IFID, so branch/halt are simply re-sampled later.
          if (!bus.stall) begin
            if (bus.branch_taken) begin
              r_pc         <= bus.jump_target;
              r_invalidate <= 1'b1;
              r_state      <= StSquash;
              if (r_taken_count != 8'hFF) begin
                r_taken_count <= r_taken_count + 8'd1;
              end
            end else if (bus.halt) begin
              r_halted <= 1'b1;
              r_state  <= StHalt;
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end
        StSquash: begin
          // IFID holds the wrong-path instruction: its branch/halt are ignored.
          if (!bus.stall) begin
            r_pc         <= r_pc + 1'b1;
            r_invalidate <= 1'b0;
            r_state      <= StRun;
          end
        end
        StHalt: begin
        end
        default: begin
          r_state      <= StRun;
          r_invalidate <= 1'b0;
          r_halted     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc               = r_pc;
  assign bus.invalidate_instr = r_invalidate;
  assign bus.halted           = r_halted;
  assign bus.taken_count      = r_taken_count;

endmodule

// File: tb/tb_ctrl_pc_redirect.sv
// Directed bench for ctrl_pc_redirect: sequential fetch, redirect, squash, stall,
// wrap, saturation, halt and asynchronous reset.
module tb_ctrl_pc_redirect;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  ctrl_pc_redirect_if #(.PC_W(8)) bus0 ();
  ctrl_pc_redirect_if #(.PC_W(8)) bus1 ();

  ctrl_pc_redirect #(.PC_W(8), .RESET_PC(8'h00)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  ctrl_pc_redirect #(.PC_W(8), .RESET_PC(8'hFE)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus0.stall = 0; bus0.branch_taken = 0; bus0.jump_target = 0; bus0.halt = 0;
    bus1.stall = 0; bus1.branch_taken = 0; bus1.jump_target = 0; bus1.halt = 0;
    #12;
    n_cmp++; if (bus0.pc !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", bus0.pc); end
    n_cmp++; if (bus0.invalidate_instr !== 1'b0) begin n_err++; $display("FAIL reset_inv: got %b want 0", bus0.invalidate_instr); end
    n_cmp++; if (bus0.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", bus0.halted); end
    n_cmp++; if (bus0.taken_count !== 8'h00) begin n_err++; $display("FAIL reset_count: got %h want 00", bus0.taken_count); end
    n_cmp++; if (bus1.pc !== 8'hFE) begin n_err++; $display("FAIL reset_pc_fe: got %h want FE", bus1.pc); end
    @(posedge clk); #3;
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++; if (bus0.pc !== 8'(i)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus0.pc, 8'(i)); end
      n_cmp++; if (bus0.invalidate_instr !== 1'b0) begin n_err++; $display("FAIL seq_inv[%0d]: got %b want 0", i, bus0.invalidate_instr); end
      if (i == 1) begin
        n_cmp++; if (bus1.pc !== 8'hFF) begin n_err++; $display("FAIL wrap_ff: got %h want FF", bus1.pc); end
      end
      if (i == 2) begin
        n_cmp++; if (bus1.pc !== 8'h00) begin n_err++; $display("FAIL wrap_00: got %h want 00", bus1.pc); end
      end
    end
    n_cmp++; if (bus0.taken_count !== 8'h00) begin n_err++; $display("FAIL seq_count: got %h want 00", bus0.taken_count); end
    tick();
  endtask

  task automatic test_taken();
    n_cmp++; if (bus0.pc !== 8'h05) begin n_err++; $display("FAIL taken_start_pc: got %h want 05", bus0.pc); end
    bus0.branch_taken = 1; bus0.jump_target = 8'h40;
    tick();
    bus0.branch_taken = 0;
    n_cmp++; if (bus0.pc !== 8'h40) begin n_err++; $display("FAIL taken_pc: got %h want 40", bus0.pc); end
    n_cmp++; if (bus0.invalidate_instr !== 1'b1) begin n_err++; $display("FAIL taken_inv: got %b want 1", bus0.invalidate_instr); end
    tick();
    n_cmp++; if (bus0.pc !== 8'h41) begin n_err++; $display("FAIL taken_pc_next: got %h want 41", bus0.pc); end
    n_cmp++; if (bus0.invalidate_instr !== 1'b0) begin n_err++; $display("FAIL taken_inv_next: got %b want 0", bus0.invalidate_instr); end
    n_cmp++; if (bus0.taken_count !== 8'h01) begin n_err++; $display("FAIL taken_count: got %h want 01", bus0.taken_count); end
  endtask

  task automatic test_wrong_path();
    bus0.branch_taken = 1; bus0.jump_target = 8'h20;
    tick();
    n_cmp++; if (bus0.pc !== 8'h20) begin n_err++; $display("FAIL wp_pc: got %h want 20", bus0.pc); end
    bus0.branch_taken = 1; bus0.jump_target = 8'h80; bus0.halt = 1;
    tick();
    bus0.branch_taken = 0; bus0.halt = 0;
    n_cmp++; if (bus0.pc !== 8'h21) begin n_err++; $display("FAIL wp_pc_next: got %h want 21", bus0.pc); end
    n_cmp++; if (bus0.taken_count !== 8'h02) begin n_err++; $display("FAIL wp_count: got %h want 02", bus0.taken_count); end
    n_cmp++; if (bus0.halted !== 1'b0) begin n_err++; $display("FAIL wp_halted: got %b want 0", bus0.halted); end
    n_cmp++; if (bus0.invalidate_instr !== 1'b0) begin n_err++; $display("FAIL wp_inv: got %b want 0", bus0.invalidate_instr); end
  endtask

  task automatic test_stall();
    bus0.stall = 1; bus0.branch_taken = 1; bus0.jump_target = 8'h60;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus0.pc !== 8'h21) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 21", i, bus0.pc); end
      n_cmp++; if (bus0.taken_count !== 8'h02) begin n_err++; $display("FAIL stall_count[%0d]: got %h want 02", i, bus0.taken_count); end
    end
    bus0.stall = 0;
    tick();
    bus0.branch_taken = 0;
    n_cmp++; if (bus0.pc !== 8'h60) begin n_err++; $display("FAIL stall_redir_pc: got %h want 60", bus0.pc); end
    n_cmp++; if (bus0.invalidate_instr !== 1'b1) begin n_err++; $display("FAIL stall_redir_inv: got %b want 1", bus0.invalidate_instr); end
    n_cmp++; if (bus0.taken_count !== 8'h03) begin n_err++; $display("FAIL stall_redir_count: got %h want 03", bus0.taken_count); end
    bus0.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus0.invalidate_instr !== 1'b1) begin n_err++; $display("FAIL sq_stall_inv[%0d]: got %b want 1", i, bus0.invalidate_instr); end
      n_cmp++; if (bus0.pc !== 8'h60) begin n_err++; $display("FAIL sq_stall_pc[%0d]: got %h want 60", i, bus0.pc); end
    end
    bus0.stall = 0;
    tick();
    n_cmp++; if (bus0.pc !== 8'h61) begin n_err++; $display("FAIL sq_release_pc: got %h want 61", bus0.pc); end
    n_cmp++; if (bus0.invalidate_instr !== 1'b0) begin n_err++; $display("FAIL sq_release_inv: got %b want 0", bus0.invalidate_instr); end
  endtask

  task automatic test_saturation();
    // Counter enters at 3; 252 more redirects reach FF exactly.
    for (int i = 0; i < 260; i++) begin
      bus0.branch_taken = 1; bus0.jump_target = 8'(i);
      tick();
      bus0.branch_taken = 0;
      tick();
      if (i == 0) begin
        n_cmp++; if (bus0.taken_count !== 8'h04) begin n_err++; $display("FAIL sat_first: got %h want 04", bus0.taken_count); end
      end
      if (i == 250) begin
        n_cmp++; if (bus0.taken_count !== 8'hFE) begin n_err++; $display("FAIL sat_fe: got %h want FE", bus0.taken_count); end
      end
      if (i == 251) begin
        n_cmp++; if (bus0.taken_count !== 8'hFF) begin n_err++; $display("FAIL sat_ff: got %h want FF", bus0.taken_count); end
      end
    end
    n_cmp++; if (bus0.taken_count !== 8'hFF) begin n_err++; $display("FAIL sat_hold: got %h want FF", bus0.taken_count); end
    n_cmp++; if (bus0.pc !== 8'h04) begin n_err++; $display("FAIL sat_pc: got %h want 04", bus0.pc); end
  endtask

  task automatic test_halt();
    bus0.branch_taken = 1; bus0.jump_target = 8'h06;
    tick();
    bus0.branch_taken = 0;
    tick();
    n_cmp++; if (bus0.pc !== 8'h07) begin n_err++; $display("FAIL halt_start_pc: got %h want 07", bus0.pc); end
    bus0.halt = 1;
    tick();
    bus0.halt = 0;
    n_cmp++; if (bus0.halted !== 1'b1) begin n_err++; $display("FAIL halt_flag: got %b want 1", bus0.halted); end
    bus0.jump_target = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      bus0.branch_taken = (i % 2 == 0);
      tick();
      n_cmp++; if (bus0.pc !== 8'h07) begin n_err++; $display("FAIL halt_pc[%0d]: got %h want 07", i, bus0.pc); end
      n_cmp++; if (bus0.halted !== 1'b1) begin n_err++; $display("FAIL halt_hold[%0d]: got %b want 1", i, bus0.halted); end
      n_cmp++; if (bus0.invalidate_instr !== 1'b0) begin n_err++; $display("FAIL halt_inv[%0d]: got %b want 0", i, bus0.invalidate_instr); end
    end
    bus0.branch_taken = 0;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus0.pc !== 8'h00) begin n_err++; $display("FAIL areset_pc: got %h want 00", bus0.pc); end
    n_cmp++; if (bus0.halted !== 1'b0) begin n_err++; $display("FAIL areset_halted: got %b want 0", bus0.halted); end
    n_cmp++; if (bus0.taken_count !== 8'h00) begin n_err++; $display("FAIL areset_count: got %h want 00", bus0.taken_count); end
    n_cmp++; if (bus1.pc !== 8'hFE) begin n_err++; $display("FAIL areset_pc_fe: got %h want FE", bus1.pc); end
    #2;
    reset_n = 1'b1;
    tick();
    n_cmp++; if (bus0.pc !== 8'h01) begin n_err++; $display("FAIL areset_resume: got %h want 01", bus0.pc); end
    // Reset in the middle of a squash.
    bus0.branch_taken = 1; bus0.jump_target = 8'h33;
    tick();
    bus0.branch_taken = 0;
    n_cmp++; if (bus0.invalidate_instr !== 1'b1) begin n_err++; $display("FAIL presq_inv: got %b want 1", bus0.invalidate_instr); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus0.invalidate_instr !== 1'b0) begin n_err++; $display("FAIL sq_reset_inv: got %b want 0", bus0.invalidate_instr); end
    n_cmp++; if (bus0.pc !== 8'h00) begin n_err++; $display("FAIL sq_reset_pc: got %h want 00", bus0.pc); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (bus0.pc !== 8'h01) begin n_err++; $display("FAIL sq_reset_resume: got %h want 01", bus0.pc); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_taken();
    test_wrong_path();
    test_stall();
    test_saturation();
    test_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
